// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(7,4) receive path: codeword sizing
// and the receive sequencer state encoding.
package hamming_pkg;

  localparam int CW_BITS_DEFAULT = 7;
  localparam int DATA_BITS       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sipo_shift_reg.sv
// Indexed serial-in/parallel-out capture register. A bit lands at an explicit
// position, so the sequencer decides ordering and no shifting ever occurs.
module sipo_shift_reg #(
  parameter int WIDTH = 7,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  // Clear takes priority so a new frame never inherits bits from the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (wr_en) begin
      q[idx] <= din;
    end
  end

endmodule

// File: rtl/hamming_rx_ctrl.sv
// Receive sequencer: frames CW_BITS serial bits after a start pulse, holds the
// assembled codeword for a valid/ready handshake and flags framing overruns.
module hamming_rx_ctrl
  import hamming_pkg::*;
#(
  parameter int CW_BITS = CW_BITS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               data_in,
  input  logic               out_ready,
  input  logic               clr_err,
  output logic               busy,
  output logic               code_valid,
  output logic [CW_BITS-1:0] code_out,
  output logic               overrun
);

  localparam int CNT_W = $clog2(CW_BITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CW_BITS - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             handshake;
  logic             violation;
  logic             cap_clr;
  logic             cap_wr;

  // A start is only legal from IDLE or when it coincides with the handshake;
  // anything else is a framing violation and is otherwise ignored.
  always_comb begin
    handshake = 1'b0;
    violation = 1'b0;
    cap_clr   = 1'b0;
    cap_wr    = 1'b0;
    case (state)
      IDLE: begin
        cap_clr = start;
      end
      SHIFT: begin
        cap_wr    = 1'b1;
        violation = start;
      end
      HOLD: begin
        handshake = out_ready;
        cap_clr   = out_ready & start;
        violation = start & ~out_ready;
      end
      default: begin
        cap_clr = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (cnt == LAST_IDX) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (handshake) begin
            state <= start ? SHIFT : IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A fresh violation outranks a simultaneous clear so no error is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (violation) begin
      overrun <= 1'b1;
    end else if (clr_err) begin
      overrun <= 1'b0;
    end
  end

  sipo_shift_reg #(
    .WIDTH (CW_BITS),
    .IDX_W (CNT_W)
  ) u_capture (
    .clk   (clk),
    .reset (reset),
    .clr   (cap_clr),
    .wr_en (cap_wr),
    .idx   (cnt),
    .din   (data_in),
    .q     (code_out)
  );

  assign busy       = (state != IDLE);
  assign code_valid = (state == HOLD);

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Directed plus randomized bench for hamming_rx_ctrl; expected codewords come
// from the serial bit lists and a queue of frames awaiting handshake.
module tb_hamming_rx_ctrl;

  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          data_in;
  logic          out_ready;
  logic          clr_err;
  logic          busy;
  logic          code_valid;
  logic [CW-1:0] code_out;
  logic          overrun;

  int   checks = 0;
  int   errors = 0;
  logic model_ovr = 1'b0;
  logic [CW-1:0] pending[$];

  always #5 clk = ~clk;

  hamming_rx_ctrl #(.CW_BITS(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .data_in    (data_in),
    .out_ready  (out_ready),
    .clr_err    (clr_err),
    .busy       (busy),
    .code_valid (code_valid),
    .code_out   (code_out),
    .overrun    (overrun)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic s, input logic d, input logic r, input logic c);
    start     = s;
    data_in   = d;
    out_ready = r;
    clr_err   = c;
  endtask

  // Start in cycle 0, bit i in cycle i+1; an optional stray start in cycle
  // start_at (1..CW). Returns in cycle CW+1 where the codeword should be valid.
  task automatic shift_frame(input logic [CW-1:0] code, input int start_at, input logic ready);
    apply_stimulus(1'b1, 1'b0, ready, 1'b0);
    step();
    for (int i = 0; i < CW; i++) begin
      apply_stimulus((i + 1) == start_at, code[i], ready, 1'b0);
      if ((i + 1) == start_at) model_ovr = 1'b1;
      step();
      if (i < CW - 1) begin
        check_output("shift_valid", 32'(code_valid), 32'd0);
        check_output("shift_busy", 32'(busy), 32'd1);
        check_output("shift_overrun", 32'(overrun), 32'(model_ovr));
      end
    end
    apply_stimulus(1'b0, 1'b0, ready, 1'b0);
  endtask

  task automatic check_hold(input string tag, input logic [CW-1:0] exp_code);
    check_output({tag, "_valid"}, 32'(code_valid), 32'd1);
    check_output({tag, "_code"}, 32'(code_out), 32'(exp_code));
    check_output({tag, "_busy"}, 32'(busy), 32'd1);
    check_output({tag, "_overrun"}, 32'(overrun), 32'(model_ovr));
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_valid"}, 32'(code_valid), 32'd0);
    check_output({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check_idle("reset");
    check_output("reset_code", 32'(code_out), 32'd0);
    check_output("reset_overrun", 32'(overrun), 32'd0);
    reset     = 1'b0;
    model_ovr = 1'b0;
    step();
  endtask

  initial begin
    logic [CW-1:0] rcode;
    int            wait_cycles;
    int            inj;

    $display("[TB] start");
    do_reset();

    // Basic frame 1,0,1,0,1,0,1
    shift_frame(7'h55, 0, 1'b1);
    check_hold("basic", 7'h55);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_idle("basic_done");
    check_output("basic_overrun", 32'(overrun), 32'd0);

    // Backpressure on frame 1,1,1,1,0,0,0
    shift_frame(7'h0F, 0, 1'b0);
    check_hold("bp_first", 7'h0F);
    for (int k = 0; k < 5; k++) begin
      step();
      check_hold("bp_stall", 7'h0F);
    end
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_idle("bp_done");
    step();
    check_idle("bp_single");

    // Stray start in SHIFT, then in HOLD without handshake
    shift_frame(7'h5A, 3, 1'b0);
    check_hold("ovr_frame", 7'h5A);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
    model_ovr = 1'b1;
    step();
    check_hold("ovr_hold_start", 7'h5A);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    model_ovr = 1'b0;
    step();
    check_hold("ovr_cleared", 7'h5A);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_idle("ovr_done");

    // Back-to-back: second start coincides with the first handshake
    shift_frame(7'h2A, 0, 1'b1);
    check_hold("b2b_first", 7'h2A);
    shift_frame(7'h63, 0, 1'b1);
    check_hold("b2b_second", 7'h63);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_idle("b2b_done");

    // Reset in cycle 4 of a frame of all ones
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
      step();
    end
    check_output("mid_partial", 32'(code_out), 32'h07);
    reset = 1'b1;
    #1;
    check_idle("mid_reset");
    check_output("mid_reset_code", 32'(code_out), 32'd0);
    step();
    reset = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check_idle("mid_after");
    shift_frame(7'h7F, 0, 1'b1);
    check_hold("mid_fresh", 7'h7F);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_idle("mid_done");

    // Random frames with random stalls and occasional stray starts
    for (int n = 0; n < 20; n++) begin
      rcode       = CW'($urandom_range(0, (1 << CW) - 1));
      wait_cycles = $urandom_range(0, 3);
      inj         = $urandom_range(0, 12);
      pending.push_back(rcode);
      shift_frame(rcode, (inj >= 1 && inj <= CW) ? inj : 0, 1'b0);
      check_hold("rand_valid", pending[0]);
      for (int w = 0; w < wait_cycles; w++) begin
        step();
        check_hold("rand_stall", pending[0]);
      end
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      step();
      void'(pending.pop_front());
      check_idle("rand_done");
      check_output("rand_overrun", 32'(overrun), 32'(model_ovr));
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      model_ovr = 1'b0;
      step();
      check_output("rand_clr", 32'(overrun), 32'd0);
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
